// File: rtl/ram_pkg.sv
// ============================================================================
// Module : ram_pkg
// Shared types, constants and address-width helper for sync_ram_be.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Address width for a given depth, never narrower than one bit.
   function automatic int clog2(input int depth);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << r) < 64'(depth)) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ram_be_if.sv
// ============================================================================
// Module : sync_ram_be_if
// Write/read/clear bus of the byte-enable RAM macro.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sync_ram_be_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 4
);
   logic               clr;
   logic               busy;
   logic               we;
   logic [AW-1:0]      waddr;
   logic [WIDTH-1:0]   din;
   logic [WIDTH/8-1:0] be;
   logic               re;
   logic [AW-1:0]      raddr;
   logic [WIDTH-1:0]   dout;
   logic               rvalid;

   modport master (
      output clr, we, waddr, din, be, re, raddr,
      input  busy, dout, rvalid
   );

   modport slave (
      input  clr, we, waddr, din, be, re, raddr,
      output busy, dout, rvalid
   );
endinterface

`default_nettype wire

// File: rtl/ram_clear_ctrl.sv
// ============================================================================
// Module : ram_clear_ctrl
// IDLE/CLEAR sequencer: walks the array writing zeros and raises busy meanwhile.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_clear_ctrl
   import ram_pkg::*;
#(
   parameter int DEPTH         = 16,
   parameter int AW            = 4,
   parameter int INIT_ON_RESET = 1
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          i_clr,
   output      logic          o_busy,
   output      logic          o_clr_we,
   output      logic [AW-1:0] o_clr_addr
);

   localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

   state_t        r_state;
   logic          r_busy;
   logic [AW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= (INIT_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         r_busy  <= (INIT_ON_RESET != 0);
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_clr) begin
                  r_state <= ST_CLEAR;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            ST_CLEAR: begin
               // Further clr pulses are ignored; the sweep never restarts.
               if (r_cnt == c_LAST) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_clr_we   = r_busy;
   assign o_clr_addr = r_cnt;

endmodule

`default_nettype wire

// File: rtl/sync_ram_be.sv
// ============================================================================
// Module : sync_ram_be
// Single-clock 1W/1R RAM with byte enables, read-during-write policy and clear engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_ram_be
   import ram_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int DEPTH         = 16,
   parameter int READ_LATENCY  = 1,
   parameter int RDW_MODE      = 0,
   parameter int INIT_ON_RESET = 1
) (
   input wire logic     clk,
   input wire logic     rst_n,
   sync_ram_be_if.slave bus
);

   localparam int             AW      = clog2(DEPTH);
   localparam int             NB      = WIDTH / 8;
   localparam logic [AW:0]    c_DEPTH = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             w_busy;
   logic             w_clr_we;
   logic [AW-1:0]    w_clr_addr;
   logic             w_wr_ok;
   logic             w_rd_ok;
   logic             w_raddr_ok;
   logic [WIDTH-1:0] w_wold;
   logic [WIDTH-1:0] w_merge;
   logic [WIDTH-1:0] w_rdata;

   logic [WIDTH-1:0] r_d1;
   logic             r_v1;

   ram_clear_ctrl #(
      .DEPTH         (DEPTH),
      .AW            (AW),
      .INIT_ON_RESET (INIT_ON_RESET)
   ) u_clr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (bus.clr),
      .o_busy     (w_busy),
      .o_clr_we   (w_clr_we),
      .o_clr_addr (w_clr_addr)
   );

   assign bus.busy   = w_busy;
   assign w_wr_ok    = !w_busy && bus.we && ({1'b0, bus.waddr} < c_DEPTH);
   assign w_rd_ok    = !w_busy && bus.re;
   assign w_raddr_ok = ({1'b0, bus.raddr} < c_DEPTH);
   assign w_wold     = mem[bus.waddr];

   always_comb begin
      w_merge = w_wold;
      for (int k = 0; k < NB; k++) begin
         if (bus.be[k]) w_merge[8*k +: 8] = bus.din[8*k +: 8];
      end
   end

   // Write-first forwarding only matters when both ports hit the same word.
   always_comb begin
      w_rdata = '0;
      if (w_raddr_ok) begin
         if (RDW_MODE == RDW_NEW && w_wr_ok && bus.waddr == bus.raddr)
            w_rdata = w_merge;
         else
            w_rdata = mem[bus.raddr];
      end
   end

   // No reset on the array so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         mem[w_clr_addr] <= '0;
      end else if (w_wr_ok) begin
         for (int k = 0; k < NB; k++) begin
            if (bus.be[k]) mem[bus.waddr][8*k +: 8] <= bus.din[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d1 <= '0;
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= w_rd_ok;
         if (w_rd_ok) r_d1 <= w_rdata;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [WIDTH-1:0] r_d2;
         logic             r_v2;

         // Not gated by busy, so reads in flight complete across a clr.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_d2 <= '0;
               r_v2 <= 1'b0;
            end else begin
               r_v2 <= r_v1;
               if (r_v1) r_d2 <= r_d1;
            end
         end

         assign bus.dout   = r_d2;
         assign bus.rvalid = r_v2;
      end else begin : g_lat1
         assign bus.dout   = r_d1;
         assign bus.rvalid = r_v1;
      end
   endgenerate

endmodule

`default_nettype wire
